pe_output: RTL and testbench

Local-delivery stage of the router's PE port, the mirror of the PE injection path. It accepts packets that the clockwise (cw) and counter-clockwise (ccw) ring input buffers have marked for the local node, on the even and odd virtual channels (VCs). It holds one packet per VC and delivers each packet to the processing element over the peso/pero/pedo handshake. Arbitration is round-robin between cw and ccw per VC, and each VC alternates between fill and drain phases under the global `polarity` signal.

---
 rtl/pe_output_if.sv | 50 +++++
 rtl/pe_output.sv | 107 ++++++++++
 tb/tb_pe_output.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_output_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_output_if
//  Description : Ring-to-PE delivery bundle for the pe_output stage. Carries
//                the per-direction/per-VC request/data/grant handshake from
//                the ring input buffers, the global phase, and the
//                peso/pero/pedo handshake towards the processing element.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_output_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  polarity;
   logic                  request_cw_even;
   logic                  request_cw_odd;
   logic                  request_ccw_even;
   logic                  request_ccw_odd;
   logic [DATA_WIDTH-1:0] data_in_cw_even;
   logic [DATA_WIDTH-1:0] data_in_cw_odd;
   logic [DATA_WIDTH-1:0] data_in_ccw_even;
   logic [DATA_WIDTH-1:0] data_in_ccw_odd;
   logic                  grant_cw_even;
   logic                  grant_cw_odd;
   logic                  grant_ccw_even;
   logic                  grant_ccw_odd;
   logic                  pero;
   logic                  peso;
   logic [DATA_WIDTH-1:0] pedo;

   // Ring buffers and PE side (everything around the delivery stage)
   modport master (
      output polarity,
      output request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
      output data_in_cw_even, data_in_cw_odd, data_in_ccw_even, data_in_ccw_odd,
      input  grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
      output pero,
      input  peso, pedo
   );

   // The delivery stage itself
   modport slave (
      input  polarity,
      input  request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
      input  data_in_cw_even, data_in_cw_odd, data_in_ccw_even, data_in_ccw_odd,
      output grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
      input  pero,
      output peso, pedo
   );
endinterface
`default_nettype wire

// File: rtl/pe_output.sv
`default_nettype none
// ============================================================================
//  Module      : pe_output
//  Description : Local-delivery stage of the router PE port. Holds one packet
//                per virtual channel (even/odd), fills each VC from the cw/ccw
//                ring buffers with round-robin arbitration during its fill
//                phase, and drains it to the PE during its drain phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_output #(
   parameter int DATA_WIDTH = 64
) (
   input  logic        clk,
   input  logic        rst,      // synchronous, active-low
   pe_output_if.slave  bus
);

   // Index 0 is the even VC, index 1 the odd VC throughout.
   localparam int c_NUM_VC = 2;

   logic [c_NUM_VC-1:0]   w_fill;
   logic [c_NUM_VC-1:0]   w_req_cw;
   logic [c_NUM_VC-1:0]   w_req_ccw;
   logic [c_NUM_VC-1:0]   w_can_fill;
   logic [c_NUM_VC-1:0]   w_grant_cw;
   logic [c_NUM_VC-1:0]   w_grant_ccw;
   logic [c_NUM_VC-1:0]   w_drain;
   logic [DATA_WIDTH-1:0] w_data_cw  [c_NUM_VC];
   logic [DATA_WIDTH-1:0] w_data_ccw [c_NUM_VC];

   logic [c_NUM_VC-1:0]   r_full;
   logic [c_NUM_VC-1:0]   r_ptr;    // 0: cw has priority, 1: ccw has priority
   logic [DATA_WIDTH-1:0] r_buf [c_NUM_VC];
   logic                  r_peso;
   logic [DATA_WIDTH-1:0] r_pedo;

   // Odd VC fills while polarity is high, even VC while it is low; the phases
   // are exclusive so the PE port only ever sees one draining VC.
   assign w_fill        = {bus.polarity, ~bus.polarity};
   assign w_req_cw      = {bus.request_cw_odd,  bus.request_cw_even};
   assign w_req_ccw     = {bus.request_ccw_odd, bus.request_ccw_even};
   assign w_data_cw[0]  = bus.data_in_cw_even;
   assign w_data_cw[1]  = bus.data_in_cw_odd;
   assign w_data_ccw[0] = bus.data_in_ccw_even;
   assign w_data_ccw[1] = bus.data_in_ccw_odd;

   assign bus.grant_cw_even  = w_grant_cw[0];
   assign bus.grant_cw_odd   = w_grant_cw[1];
   assign bus.grant_ccw_even = w_grant_ccw[0];
   assign bus.grant_ccw_odd  = w_grant_ccw[1];
   assign bus.peso           = r_peso;
   assign bus.pedo           = r_pedo;

   // Round-robin grant per VC: only an empty VC in its fill phase, out of reset
   always_comb begin
      w_can_fill  = '0;
      w_grant_cw  = '0;
      w_grant_ccw = '0;
      w_drain     = '0;
      for (int v = 0; v < c_NUM_VC; v++) begin
         w_can_fill[v]  = rst & w_fill[v] & ~r_full[v];
         w_grant_cw[v]  = w_can_fill[v] & w_req_cw[v]  & (~w_req_ccw[v] | ~r_ptr[v]);
         w_grant_ccw[v] = w_can_fill[v] & w_req_ccw[v] & (~w_req_cw[v]  |  r_ptr[v]);
         w_drain[v]     = ~w_fill[v] & r_full[v] & bus.pero;
      end
   end

   // Per-VC buffer: capture on grant (pointer moves off the winner), clear on drain
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_full <= '0;
         r_ptr  <= '0;
      end else begin
         for (int v = 0; v < c_NUM_VC; v++) begin
            if (w_grant_cw[v]) begin
               r_buf[v]  <= w_data_cw[v];
               r_full[v] <= 1'b1;
               r_ptr[v]  <= 1'b1;
            end else if (w_grant_ccw[v]) begin
               r_buf[v]  <= w_data_ccw[v];
               r_full[v] <= 1'b1;
               r_ptr[v]  <= 1'b0;
            end else if (w_drain[v]) begin
               r_full[v] <= 1'b0;
            end
         end
      end
   end

   // PE delivery register: one-cycle peso pulse, pedo holds between packets
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_peso <= 1'b0;
         r_pedo <= '0;
      end else if (w_drain[0]) begin
         r_peso <= 1'b1;
         r_pedo <= r_buf[0];
      end else if (w_drain[1]) begin
         r_peso <= 1'b1;
         r_pedo <= r_buf[1];
      end else begin
         r_peso <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_output.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_output
//  Description : Self-checking bench for pe_output. Sources are modelled as
//                ring buffers that hold a packet until granted; a one-slot
//                mailbox per VC predicts grants and PE deliveries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_output;

   localparam int c_DW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            pol;
   logic            pero_r;
   // source index: 0 cw_even, 1 cw_odd, 2 ccw_even, 3 ccw_odd
   logic [3:0]      src_req;
   logic [c_DW-1:0] src_data [4];

   // reference mailbox state
   logic            m_full [2];
   logic [c_DW-1:0] m_buf  [2];
   logic            m_ccw_pref [2];
   logic [3:0]      e_g;
   logic            e_peso;
   logic [c_DW-1:0] e_pedo;

   // observed values
   logic [3:0]      o_g;
   logic            o_peso;
   logic [c_DW-1:0] o_pedo;

   int n_cmp = 0;
   int n_err = 0;

   pe_output_if #(.DATA_WIDTH(c_DW)) bus ();

   pe_output #(.DATA_WIDTH(c_DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.polarity         = pol;
   assign bus.pero             = pero_r;
   assign bus.request_cw_even  = src_req[0];
   assign bus.request_cw_odd   = src_req[1];
   assign bus.request_ccw_even = src_req[2];
   assign bus.request_ccw_odd  = src_req[3];
   assign bus.data_in_cw_even  = src_data[0];
   assign bus.data_in_cw_odd   = src_data[1];
   assign bus.data_in_ccw_even = src_data[2];
   assign bus.data_in_ccw_odd  = src_data[3];

   always #5 clk = ~clk;

   function automatic logic [c_DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Which sources should win this cycle according to the mailbox rules
   task automatic predict();
      e_g = 4'b0000;
      for (int v = 0; v < 2; v++) begin
         logic fill_phase = (v == 1) ? pol : !pol;
         logic cw  = src_req[v];
         logic ccw = src_req[2+v];
         if (rst && fill_phase && !m_full[v]) begin
            if (cw && ccw) begin
               if (m_ccw_pref[v]) e_g[2+v] = 1'b1;
               else               e_g[v]   = 1'b1;
            end else if (cw) begin
               e_g[v] = 1'b1;
            end else if (ccw) begin
               e_g[2+v] = 1'b1;
            end
         end
      end
   endtask

   // Mailbox update at the clock edge, using pre-edge inputs
   task automatic advance();
      if (!rst) begin
         for (int v = 0; v < 2; v++) begin
            m_full[v]     = 1'b0;
            m_ccw_pref[v] = 1'b0;
         end
         e_peso = 1'b0;
         e_pedo = '0;
      end else begin
         e_peso = 1'b0;
         for (int v = 0; v < 2; v++) begin
            logic fill_phase = (v == 1) ? pol : !pol;
            if (!fill_phase && m_full[v] && pero_r) begin
               e_peso    = 1'b1;
               e_pedo    = m_buf[v];
               m_full[v] = 1'b0;
            end
         end
         for (int v = 0; v < 2; v++) begin
            if (e_g[v]) begin
               m_buf[v] = src_data[v];   m_full[v] = 1'b1; m_ccw_pref[v] = 1'b1;
            end else if (e_g[2+v]) begin
               m_buf[v] = src_data[2+v]; m_full[v] = 1'b1; m_ccw_pref[v] = 1'b0;
            end
         end
      end
   endtask

   // One clock: observe grants mid-cycle, update model at the edge, observe outputs after it
   task automatic do_cycle();
      predict();
      @(negedge clk);
      o_g = {bus.grant_ccw_odd, bus.grant_ccw_even, bus.grant_cw_odd, bus.grant_cw_even};
      @(posedge clk);
      advance();
      #1;
      o_peso = bus.peso;
      o_pedo = bus.pedo;
      for (int s = 0; s < 4; s++)
         if (o_g[s]) src_req[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; pol = 1'b0; pero_r = 1'b1;
      src_req = 4'b1111;
      for (int s = 0; s < 4; s++) src_data[s] = rnd64();
      for (int i = 0; i < 2; i++) begin
         do_cycle();
         n_cmp++; if (o_g !== 4'b0000) begin n_err++; $display("FAIL reset_grants got %b exp 0000", o_g); end
         n_cmp++; if (o_peso !== 1'b0) begin n_err++; $display("FAIL reset_peso got %b exp 0", o_peso); end
         n_cmp++; if (o_pedo !== 64'd0) begin n_err++; $display("FAIL reset_pedo got %h exp 0", o_pedo); end
      end
      rst = 1'b1;
      do_cycle();
      n_cmp++; if (o_g !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b exp 0001", o_g); end
      n_cmp++; if (o_g !== e_g) begin n_err++; $display("FAIL reset_first_model got %b exp %b", o_g, e_g); end
   endtask

   task automatic test_flush();
      src_req = 4'b0000; pero_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pol = i[0];
         do_cycle();
         n_cmp++; if (o_g !== e_g) begin n_err++; $display("FAIL flush_grants got %b exp %b", o_g, e_g); end
         n_cmp++; if (o_peso !== e_peso) begin n_err++; $display("FAIL flush_peso got %b exp %b", o_peso, e_peso); end
         n_cmp++; if (o_pedo !== e_pedo) begin n_err++; $display("FAIL flush_pedo got %h exp %h", o_pedo, e_pedo); end
      end
   endtask

   task automatic test_single_cw_even();
      pol = 1'b0; pero_r = 1'b1;
      src_req = 4'b0001; src_data[0] = 64'hA5A5_0000_0000_0001;
      do_cycle();
      n_cmp++; if (o_g !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b exp 0001", o_g); end
      n_cmp++; if (o_peso !== 1'b0) begin n_err++; $display("FAIL single_peso_early got %b exp 0", o_peso); end
      pol = 1'b1;
      do_cycle();
      n_cmp++; if (o_peso !== 1'b1) begin n_err++; $display("FAIL single_peso got %b exp 1", o_peso); end
      n_cmp++; if (o_pedo !== 64'hA5A5_0000_0000_0001) begin n_err++; $display("FAIL single_pedo got %h exp a5a5000000000001", o_pedo); end
      pol = 1'b0;
      do_cycle();
      n_cmp++; if (o_peso !== 1'b0) begin n_err++; $display("FAIL single_peso_pulse got %b exp 0", o_peso); end
   endtask

   task automatic test_round_robin();
      int last_dir = -1;
      int n_grants = 0;
      pero_r = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pol = ~i[0];
         if (!src_req[1]) begin src_req[1] = 1'b1; src_data[1] = rnd64(); end
         if (!src_req[3]) begin src_req[3] = 1'b1; src_data[3] = rnd64(); end
         do_cycle();
         n_cmp++; if (o_g !== e_g) begin n_err++; $display("FAIL rr_grants got %b exp %b", o_g, e_g); end
         n_cmp++; if (o_peso !== e_peso) begin n_err++; $display("FAIL rr_peso got %b exp %b", o_peso, e_peso); end
         n_cmp++; if (o_pedo !== e_pedo) begin n_err++; $display("FAIL rr_pedo got %h exp %h", o_pedo, e_pedo); end
         if (o_g[1] || o_g[3]) begin
            int dir = o_g[3] ? 1 : 0;
            n_grants++;
            n_cmp++; if (dir == last_dir) begin n_err++; $display("FAIL rr_alternate got dir %0d exp dir %0d", dir, 1 - last_dir); end
            last_dir = dir;
         end
      end
      n_cmp++; if (n_grants < 4) begin n_err++; $display("FAIL rr_count got %0d exp >=4", n_grants); end
      src_req = 4'b0000;
   endtask

   task automatic test_backpressure();
      pol = 1'b0; pero_r = 1'b1;
      src_req = 4'b0001; src_data[0] = rnd64();
      do_cycle();
      n_cmp++; if (o_g !== 4'b0001) begin n_err++; $display("FAIL bp_fill got %b exp 0001", o_g); end
      pero_r = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pol = ~i[0];
         src_req[0] = 1'b1; src_req[2] = 1'b1;
         do_cycle();
         n_cmp++; if ((o_g[0] | o_g[2]) !== 1'b0) begin n_err++; $display("FAIL bp_grants got %b exp even 0", o_g); end
         n_cmp++; if (o_peso !== 1'b0) begin n_err++; $display("FAIL bp_peso got %b exp 0", o_peso); end
      end
      pol = 1'b1; pero_r = 1'b1;
      do_cycle();
      n_cmp++; if (o_peso !== 1'b1) begin n_err++; $display("FAIL bp_deliver got %b exp 1", o_peso); end
      n_cmp++; if (o_pedo !== e_pedo) begin n_err++; $display("FAIL bp_pedo got %h exp %h", o_pedo, e_pedo); end
      do_cycle();
      n_cmp++; if (o_peso !== 1'b0) begin n_err++; $display("FAIL bp_once got %b exp 0", o_peso); end
      src_req = 4'b0000;
   endtask

   task automatic test_phase();
      pol = 1'b1; pero_r = 1'b1;
      src_req = 4'b0011; src_data[0] = rnd64(); src_data[1] = rnd64();
      for (int i = 0; i < 4; i++) begin
         do_cycle();
         n_cmp++; if (o_g[0] !== 1'b0) begin n_err++; $display("FAIL phase_even got %b exp 0", o_g[0]); end
         n_cmp++; if (o_g !== e_g) begin n_err++; $display("FAIL phase_grants got %b exp %b", o_g, e_g); end
      end
      n_cmp++; if (src_req[1] !== 1'b0) begin n_err++; $display("FAIL phase_odd_granted got req %b exp 0", src_req[1]); end
      src_req = 4'b0000;
   endtask

   task automatic test_back_to_back();
      logic [c_DW-1:0] d_even = rnd64();
      logic [c_DW-1:0] d_odd  = rnd64();
      pero_r = 1'b1;
      pol = 1'b0; src_req = 4'b0001; src_data[0] = d_even;
      do_cycle();
      pol = 1'b1; src_req = 4'b0010; src_data[1] = d_odd;
      do_cycle();
      n_cmp++; if (o_peso !== 1'b1 || o_pedo !== d_even) begin n_err++; $display("FAIL b2b_even got %b/%h exp 1/%h", o_peso, o_pedo, d_even); end
      pol = 1'b0;
      do_cycle();
      n_cmp++; if (o_peso !== 1'b1 || o_pedo !== d_odd) begin n_err++; $display("FAIL b2b_odd got %b/%h exp 1/%h", o_peso, o_pedo, d_odd); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         pol    = $urandom_range(0, 1);
         pero_r = ($urandom_range(0, 3) != 0);
         rst    = ($urandom_range(0, 49) != 0);
         for (int s = 0; s < 4; s++)
            if (!src_req[s] && $urandom_range(0, 1)) begin src_req[s] = 1'b1; src_data[s] = rnd64(); end
         do_cycle();
         n_cmp++; if (o_g !== e_g) begin n_err++; $display("FAIL rand_grants cyc %0d got %b exp %b", i, o_g, e_g); end
         n_cmp++; if (o_peso !== e_peso) begin n_err++; $display("FAIL rand_peso cyc %0d got %b exp %b", i, o_peso, e_peso); end
         n_cmp++; if (o_pedo !== e_pedo) begin n_err++; $display("FAIL rand_pedo cyc %0d got %h exp %h", i, o_pedo, e_pedo); end
      end
      rst = 1'b1;
   endtask

   initial begin
      for (int v = 0; v < 2; v++) begin
         m_full[v] = 1'b0; m_buf[v] = '0; m_ccw_pref[v] = 1'b0;
      end
      e_peso = 1'b0; e_pedo = '0;
      test_reset();
      test_flush();
      test_single_cw_even();
      test_flush();
      test_round_robin();
      test_flush();
      test_backpressure();
      test_flush();
      test_phase();
      test_flush();
      test_back_to_back();
      test_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
